// File: rtl/calc_operand_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_operand_memory_if
// Purpose  : Keypad / ALU bundle between the calculator front end and the
//            operand store.
// Revision : 1.0
// ============================================================================
interface calc_operand_memory_if #(
    parameter int WIDTH      = 16,
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGITS = 4
);
    localparam int c_cnt_w = $clog2(MAX_DIGITS + 1);

    logic [DIGIT_W-1:0] num;
    logic               num_valid;
    logic [1:0]         operator;
    logic               op_valid;
    logic               equ_enable;
    logic               clear_enable;
    logic [WIDTH-1:0]   res;
    logic               res_valid;
    logic [WIDTH-1:0]   save1;
    logic [WIDTH-1:0]   save2;
    logic [3:0]         op_out;
    logic               calc_go;
    logic [c_cnt_w-1:0] digit_cnt;
    logic               overflow;
    logic [2:0]         state;

    modport master (
        output num, num_valid, operator, op_valid, equ_enable, clear_enable,
               res, res_valid,
        input  save1, save2, op_out, calc_go, digit_cnt, overflow, state
    );

    modport slave (
        input  num, num_valid, operator, op_valid, equ_enable, clear_enable,
               res, res_valid,
        output save1, save2, op_out, calc_go, digit_cnt, overflow, state
    );
endinterface
`default_nettype wire

// File: rtl/calc_operand_memory.sv
`default_nettype none
// ============================================================================
// Module   : calc_operand_memory
// Purpose  : Operand/operator store: builds decimal operands from keypad
//            digits and sequences the ALU calculate/write-back handshake.
// Revision : 1.0
// ============================================================================
module calc_operand_memory #(
    parameter int WIDTH      = 16,
    parameter int DIGIT_W    = 4,
    parameter int RADIX      = 10,
    parameter int MAX_DIGITS = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    calc_operand_memory_if.slave   bus
);
    localparam int c_cnt_w = $clog2(MAX_DIGITS + 1);
    localparam int c_ext_w = WIDTH + DIGIT_W + 4;
    localparam logic [c_ext_w-1:0] c_max = {{(DIGIT_W + 4){1'b0}}, {WIDTH{1'b1}}};

    localparam logic [2:0] c_entry_a = 3'd0;
    localparam logic [2:0] c_op_wait = 3'd1;
    localparam logic [2:0] c_entry_b = 3'd2;
    localparam logic [2:0] c_calc    = 3'd3;
    localparam logic [2:0] c_result  = 3'd4;

    logic [2:0]         r_state,   w_state_n;
    logic [WIDTH-1:0]   r_save1,   w_save1_n;
    logic [WIDTH-1:0]   r_save2,   w_save2_n;
    logic [WIDTH-1:0]   r_last_b,  w_last_b_n;
    logic [3:0]         r_op,      w_op_n;
    logic [c_cnt_w-1:0] r_cnt,     w_cnt_n;
    logic               r_ovf,     w_ovf_n;
    logic               r_calc_go, w_calc_go_n;

    logic               w_do_res, w_do_equ, w_do_op, w_do_num;
    logic [3:0]         w_onehot;
    logic [WIDTH-1:0]   w_target;
    logic [WIDTH-1:0]   w_digit;
    logic [c_ext_w-1:0] w_num_ext, w_acc;
    logic               w_digit_bad, w_cnt_full, w_too_big;

    // Single winner among coincident strobes; clear is handled in the register
    assign w_do_res = bus.res_valid;
    assign w_do_equ = bus.equ_enable & ~bus.res_valid;
    assign w_do_op  = bus.op_valid & ~bus.equ_enable & ~bus.res_valid;
    assign w_do_num = bus.num_valid & ~bus.op_valid & ~bus.equ_enable & ~bus.res_valid;

    assign w_onehot    = 4'b0001 << bus.operator;
    assign w_target    = (r_state == c_entry_b) ? r_save2 : r_save1;
    assign w_num_ext   = c_ext_w'(bus.num);
    assign w_digit     = WIDTH'(bus.num);
    assign w_acc       = c_ext_w'(w_target) * c_ext_w'(RADIX) + w_num_ext;
    assign w_digit_bad = (w_num_ext >= c_ext_w'(RADIX));
    assign w_cnt_full  = (r_cnt == c_cnt_w'(MAX_DIGITS));
    assign w_too_big   = (w_acc > c_max);

    always_comb begin
        w_state_n   = r_state;
        w_save1_n   = r_save1;
        w_save2_n   = r_save2;
        w_last_b_n  = r_last_b;
        w_op_n      = r_op;
        w_cnt_n     = r_cnt;
        w_ovf_n     = r_ovf;
        w_calc_go_n = 1'b0;

        case (r_state)
            c_entry_a: begin
                if (w_do_op) begin
                    w_op_n    = w_onehot;
                    w_cnt_n   = '0;
                    w_state_n = c_op_wait;
                end else if (w_do_num) begin
                    if (w_digit_bad) begin
                        w_ovf_n = 1'b1;
                    end else if (!w_cnt_full) begin
                        if (w_too_big) begin
                            w_ovf_n = 1'b1;
                        end else begin
                            w_save1_n = w_acc[WIDTH-1:0];
                            w_cnt_n   = r_cnt + 1'b1;
                        end
                    end
                end
            end
            c_op_wait: begin
                if (w_do_op) begin
                    w_op_n = w_onehot;
                end else if (w_do_num) begin
                    if (w_digit_bad) begin
                        w_ovf_n = 1'b1;
                    end else begin
                        w_save2_n = w_digit;
                        w_cnt_n   = c_cnt_w'(1);
                        w_state_n = c_entry_b;
                    end
                end
            end
            c_entry_b: begin
                if (w_do_equ) begin
                    w_last_b_n  = r_save2;
                    w_calc_go_n = 1'b1;
                    w_state_n   = c_calc;
                end else if (w_do_num) begin
                    if (w_digit_bad) begin
                        w_ovf_n = 1'b1;
                    end else if (!w_cnt_full) begin
                        if (w_too_big) begin
                            w_ovf_n = 1'b1;
                        end else begin
                            w_save2_n = w_acc[WIDTH-1:0];
                            w_cnt_n   = r_cnt + 1'b1;
                        end
                    end
                end
            end
            c_calc: begin
                if (w_do_res) begin
                    w_save1_n = bus.res;
                    w_save2_n = '0;
                    w_cnt_n   = '0;
                    w_state_n = c_result;
                end
            end
            c_result: begin
                if (w_do_equ) begin
                    // Repeat the last operation against the new result
                    w_save2_n   = r_last_b;
                    w_calc_go_n = 1'b1;
                    w_state_n   = c_calc;
                end else if (w_do_op) begin
                    w_op_n    = w_onehot;
                    w_state_n = c_op_wait;
                end else if (w_do_num) begin
                    if (w_digit_bad) begin
                        w_ovf_n = 1'b1;
                    end else begin
                        w_save1_n = w_digit;
                        w_op_n    = 4'b0000;
                        w_cnt_n   = c_cnt_w'(1);
                        w_state_n = c_entry_a;
                    end
                end
            end
            default: w_state_n = c_entry_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear_enable) begin
            r_state   <= c_entry_a;
            r_save1   <= '0;
            r_save2   <= '0;
            r_last_b  <= '0;
            r_op      <= 4'b0000;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_calc_go <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_save1   <= w_save1_n;
            r_save2   <= w_save2_n;
            r_last_b  <= w_last_b_n;
            r_op      <= w_op_n;
            r_cnt     <= w_cnt_n;
            r_ovf     <= w_ovf_n;
            r_calc_go <= w_calc_go_n;
        end
    end

    assign bus.save1     = r_save1;
    assign bus.save2     = r_save2;
    assign bus.op_out    = r_op;
    assign bus.calc_go   = r_calc_go;
    assign bus.digit_cnt = r_cnt;
    assign bus.overflow  = r_ovf;
    assign bus.state     = r_state;
endmodule
`default_nettype wire

// File: tb/tb_calc_operand_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_operand_memory
// Purpose  : Vector-table and scoreboard bench for the operand store
//            (16-bit instance plus a 12-bit instance for overflow).
// Revision : 1.0
// ============================================================================
module tb_calc_operand_memory;
    typedef struct {
        logic        rst, clr, nv;
        logic [3:0]  num;
        logic        ov;
        logic [1:0]  op;
        logic        eq, rv;
        logic [15:0] res;
        logic [15:0] s1, s2;
        logic [3:0]  opo;
        logic [2:0]  cnt;
        logic        ovf;
        logic [2:0]  st;
        logic        go;
    } vec_t;

    typedef struct {
        logic [15:0] s1, s2;
        logic [3:0]  opo;
        logic [2:0]  cnt;
        logic        ovf;
        logic [2:0]  st;
        logic        go;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst12 = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[39];
    exp_t sb[$];

    always #5 clk = ~clk;

    calc_operand_memory_if #(.WIDTH(16), .DIGIT_W(4), .MAX_DIGITS(4)) if16 ();
    calc_operand_memory_if #(.WIDTH(12), .DIGIT_W(4), .MAX_DIGITS(4)) if12 ();

    calc_operand_memory #(.WIDTH(16), .DIGIT_W(4), .RADIX(10), .MAX_DIGITS(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    calc_operand_memory #(.WIDTH(12), .DIGIT_W(4), .RADIX(10), .MAX_DIGITS(4)) u_dut12 (
        .clk (clk),
        .rst (rst12),
        .bus (if12.slave)
    );

    function automatic vec_t mk(input int r, c, nv, n, ov, o, eq, rv, rs,
                                input int s1, s2, opo, cnt, ovf, st, go);
        vec_t v;
        v.rst = 1'(r);   v.clr = 1'(c);   v.nv = 1'(nv);  v.num = 4'(n);
        v.ov  = 1'(ov);  v.op  = 2'(o);   v.eq = 1'(eq);  v.rv  = 1'(rv);
        v.res = 16'(rs); v.s1  = 16'(s1); v.s2 = 16'(s2); v.opo = 4'(opo);
        v.cnt = 3'(cnt); v.ovf = 1'(ovf); v.st = 3'(st);  v.go  = 1'(go);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply16(input int idx, input vec_t v);
        exp_t e;
        rst                  = v.rst;
        if16.clear_enable    = v.clr;
        if16.num_valid       = v.nv;
        if16.num             = v.num;
        if16.op_valid        = v.ov;
        if16.operator        = v.op;
        if16.equ_enable      = v.eq;
        if16.res_valid       = v.rv;
        if16.res             = v.res;
        sb.push_back('{s1: v.s1, s2: v.s2, opo: v.opo, cnt: v.cnt, ovf: v.ovf, st: v.st, go: v.go});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("save1",     idx, 32'(if16.save1),     32'(e.s1));
        chk("save2",     idx, 32'(if16.save2),     32'(e.s2));
        chk("op_out",    idx, 32'(if16.op_out),    32'(e.opo));
        chk("digit_cnt", idx, 32'(if16.digit_cnt), 32'(e.cnt));
        chk("overflow",  idx, 32'(if16.overflow),  32'(e.ovf));
        chk("state",     idx, 32'(if16.state),     32'(e.st));
        chk("calc_go",   idx, 32'(if16.calc_go),   32'(e.go));
    endtask

    task automatic step12(input int idx, input logic r, input logic nv, input logic [3:0] n,
                          input int s1, input int cnt, input int ovf);
        exp_t e;
        rst12          = r;
        if12.num_valid = nv;
        if12.num       = n;
        sb.push_back('{s1: 16'(s1), s2: 16'd0, opo: 4'd0, cnt: 3'(cnt), ovf: 1'(ovf), st: 3'd0, go: 1'b0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("w12_save1",     idx, 32'(if12.save1),     32'(e.s1));
        chk("w12_digit_cnt", idx, 32'(if12.digit_cnt), 32'(e.cnt));
        chk("w12_overflow",  idx, 32'(if12.overflow),  32'(e.ovf));
        chk("w12_state",     idx, 32'(if12.state),     32'(e.st));
    endtask

    initial begin
        if16.num = '0; if16.num_valid = 1'b0; if16.operator = '0; if16.op_valid = 1'b0;
        if16.equ_enable = 1'b0; if16.clear_enable = 1'b0; if16.res = '0; if16.res_valid = 1'b0;
        if12.num = '0; if12.num_valid = 1'b0; if12.operator = '0; if12.op_valid = 1'b0;
        if12.equ_enable = 1'b0; if12.clear_enable = 1'b0; if12.res = '0; if12.res_valid = 1'b0;

        //              rst clr nv num ov op eq rv res     s1    s2 opo cnt ovf st go
        vecs[0]  = mk(1, 0, 0, 0,   0, 0, 0, 0, 0,     0,    0,  0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 1,   0, 0, 0, 0, 0,     1,    0,  0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 2,   0, 0, 0, 0, 0,     12,   0,  0, 2, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 3,   0, 0, 0, 0, 0,     123,  0,  0, 3, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0,   0, 0, 0, 0, 0,     0,    0,  0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 1,   0, 0, 0, 0, 0,     1,    0,  0, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 2,   0, 0, 0, 0, 0,     12,   0,  0, 2, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0,   1, 0, 0, 0, 0,     12,   0,  1, 0, 0, 1, 0);
        vecs[8]  = mk(0, 0, 1, 3,   0, 0, 0, 0, 0,     12,   3,  1, 1, 0, 2, 0);
        vecs[9]  = mk(0, 0, 1, 4,   0, 0, 0, 0, 0,     12,   34, 1, 2, 0, 2, 0);
        vecs[10] = mk(0, 0, 0, 0,   0, 0, 1, 0, 0,     12,   34, 1, 2, 0, 3, 1);
        vecs[11] = mk(0, 0, 0, 0,   0, 0, 0, 0, 0,     12,   34, 1, 2, 0, 3, 0);
        vecs[12] = mk(0, 0, 1, 5,   0, 0, 0, 0, 0,     12,   34, 1, 2, 0, 3, 0);
        vecs[13] = mk(0, 0, 0, 0,   0, 0, 0, 1, 46,    46,   0,  1, 0, 0, 4, 0);
        vecs[14] = mk(0, 0, 0, 0,   1, 2, 0, 0, 0,     46,   0,  4, 0, 0, 1, 0);
        vecs[15] = mk(0, 0, 1, 2,   0, 0, 0, 0, 0,     46,   2,  4, 1, 0, 2, 0);
        vecs[16] = mk(0, 0, 0, 0,   0, 0, 1, 0, 0,     46,   2,  4, 1, 0, 3, 1);
        vecs[17] = mk(0, 0, 0, 0,   0, 0, 0, 1, 92,    92,   0,  4, 0, 0, 4, 0);
        vecs[18] = mk(0, 0, 0, 0,   0, 0, 1, 0, 0,     92,   2,  4, 0, 0, 3, 1);
        vecs[19] = mk(0, 0, 0, 0,   0, 0, 0, 0, 0,     92,   2,  4, 0, 0, 3, 0);
        vecs[20] = mk(0, 0, 0, 0,   0, 0, 0, 1, 184,   184,  0,  4, 0, 0, 4, 0);
        vecs[21] = mk(0, 0, 1, 7,   0, 0, 0, 0, 0,     7,    0,  0, 1, 0, 0, 0);
        vecs[22] = mk(0, 0, 1, 12,  0, 0, 0, 0, 0,     7,    0,  0, 1, 1, 0, 0);
        vecs[23] = mk(0, 0, 1, 5,   0, 0, 0, 0, 0,     75,   0,  0, 2, 1, 0, 0);
        vecs[24] = mk(0, 1, 0, 0,   0, 0, 0, 0, 0,     0,    0,  0, 0, 0, 0, 0);
        vecs[25] = mk(0, 0, 1, 6,   0, 0, 0, 0, 0,     6,    0,  0, 1, 0, 0, 0);
        vecs[26] = mk(0, 0, 1, 5,   0, 0, 0, 0, 0,     65,   0,  0, 2, 0, 0, 0);
        vecs[27] = mk(0, 0, 1, 5,   0, 0, 0, 0, 0,     655,  0,  0, 3, 0, 0, 0);
        vecs[28] = mk(0, 0, 1, 3,   0, 0, 0, 0, 0,     6553, 0,  0, 4, 0, 0, 0);
        vecs[29] = mk(0, 0, 1, 6,   0, 0, 0, 0, 0,     6553, 0,  0, 4, 0, 0, 0);
        vecs[30] = mk(0, 0, 0, 0,   1, 1, 0, 0, 0,     6553, 0,  2, 0, 0, 1, 0);
        vecs[31] = mk(0, 0, 0, 0,   0, 0, 1, 0, 0,     6553, 0,  2, 0, 0, 1, 0);
        vecs[32] = mk(0, 0, 1, 9,   0, 0, 0, 0, 0,     6553, 9,  2, 1, 0, 2, 0);
        vecs[33] = mk(0, 0, 0, 0,   1, 3, 0, 0, 0,     6553, 9,  2, 1, 0, 2, 0);
        vecs[34] = mk(0, 0, 1, 1,   1, 3, 1, 0, 0,     6553, 9,  2, 1, 0, 3, 1);
        vecs[35] = mk(0, 1, 1, 2,   1, 2, 0, 1, 1234,  0,    0,  0, 0, 0, 0, 0);
        vecs[36] = mk(0, 0, 0, 0,   0, 0, 0, 1, 55,    0,    0,  0, 0, 0, 0, 0);
        vecs[37] = mk(0, 0, 1, 4,   0, 0, 0, 0, 0,     4,    0,  0, 1, 0, 0, 0);
        vecs[38] = mk(0, 0, 1, 3,   1, 3, 0, 0, 0,     4,    0,  8, 0, 0, 1, 0);

        @(negedge clk);
        for (int i = 0; i < 39; i++) apply16(i, vecs[i]);

        // 12-bit instance: fourth 9 would make 9999 > 4095
        step12(100, 1'b1, 1'b0, 4'd0, 0,   0, 0);
        step12(101, 1'b0, 1'b1, 4'd9, 9,   1, 0);
        step12(102, 1'b0, 1'b1, 4'd9, 99,  2, 0);
        step12(103, 1'b0, 1'b1, 4'd9, 999, 3, 0);
        step12(104, 1'b0, 1'b1, 4'd9, 999, 3, 1);
        step12(105, 1'b0, 1'b0, 4'd0, 999, 3, 1);
        step12(106, 1'b1, 1'b0, 4'd0, 0,   0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
